// File: rtl/multicycle_alu.sv
//------------------------------------------------------------------------------
// Module      : multicycle_alu
// Description : Registered multi-cycle ALU with start/ready/valid handshake.
//               Shifts iterate one bit per cycle. The optional shift-add
//               multiplier is built when MULTICYCLE_ALU_MUL_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_alu #(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] CNT_ONE = (SHAMT_W+1)'(1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LUI = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8;
  localparam logic [3:0] OP_BNE = 4'd9;
`ifdef MULTICYCLE_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [SHAMT_W:0] CNT_MUL = (SHAMT_W+1)'(WIDTH);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               shift_q, shift_d;
  logic [SHAMT_W:0]   cnt_q, cnt_d;
`ifdef MULTICYCLE_ALU_MUL_EN
  logic [WIDTH-1:0]   acc_q, acc_d;
`endif

  logic [SHAMT_W-1:0] w_amt;
  logic [WIDTH-1:0]   w_step_a;
  logic [WIDTH-1:0]   w_final;

  always_comb begin
    w_amt    = B_i[SHAMT_W-1:0];
    w_step_a = a_q;
    w_final  = '0;
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    zero_d   = zero_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
`ifdef MULTICYCLE_ALU_MUL_EN
    acc_d    = acc_q;
`endif

    // a_q is the working register: shifted value for SLL/SRL, multiplicand for MUL
    case (op_q)
      OP_SLL: if (shift_q) w_step_a = {a_q[WIDTH-2:0], 1'b0};
      OP_SRL: if (shift_q) w_step_a = {1'b0, a_q[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_MUL_EN
      OP_MUL: w_step_a = {a_q[WIDTH-2:0], 1'b0};
`endif
      default: ;
    endcase

    case (op_q)
      OP_ADD:         w_final = a_q + b_q;
      OP_SUB:         w_final = a_q - b_q;
      OP_OR:          w_final = a_q | b_q;
      OP_AND:         w_final = a_q & b_q;
      OP_XOR:         w_final = a_q ^ b_q;
      OP_LUI:         w_final = b_q << LUI_SHIFT;
      OP_SLL, OP_SRL: w_final = w_step_a;
      OP_BEQ:         w_final = b_q - a_q;
      OP_BNE:         w_final = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
`ifdef MULTICYCLE_ALU_MUL_EN
      OP_MUL:         w_final = acc_q + (b_q[0] ? a_q : '0);
`endif
      default:        w_final = '0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = ALU_Operation_i;
          a_d     = A_i;
          b_d     = B_i;
          shift_d = (w_amt != '0);
          cnt_d   = CNT_ONE;
          if ((ALU_Operation_i == OP_SLL || ALU_Operation_i == OP_SRL) && shift_d)
            cnt_d = {1'b0, w_amt};
`ifdef MULTICYCLE_ALU_MUL_EN
          if (ALU_Operation_i == OP_MUL) begin
            cnt_d = CNT_MUL;
            acc_d = '0;
          end
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        a_d   = w_step_a;
        cnt_d = cnt_q - CNT_ONE;
`ifdef MULTICYCLE_ALU_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d = w_final;
          b_d   = b_q >> 1;
        end
`endif
        if (cnt_q == CNT_ONE) begin
          res_d   = w_final;
          zero_d  = (w_final == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      shift_q <= 1'b0;
      cnt_q   <= '0;
`ifdef MULTICYCLE_ALU_MUL_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef MULTICYCLE_ALU_MUL_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign ready_o      = (state_q == ST_IDLE);
  assign valid_o      = (state_q == ST_DONE);
  assign ALU_Result_o = res_q;
  assign Zero_o       = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_alu
// Description : Self-checking bench for multicycle_alu (WIDTH 32 and 8 instances)
//               against a cycle-count reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_alu;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

`ifdef MULTICYCLE_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        start32 = 1'b0;
  logic [3:0]  op32    = '0;
  logic [31:0] a32     = '0;
  logic [31:0] b32     = '0;
  logic        ready32, valid32, zero32;
  logic [31:0] res32;

  logic        start8 = 1'b0;
  logic [3:0]  op8    = '0;
  logic [7:0]  a8     = '0;
  logic [7:0]  b8     = '0;
  logic        ready8, valid8, zero8;
  logic [7:0]  res8;

  multicycle_alu #(.WIDTH(32), .LUI_SHIFT(12)) u_dut32 (
    .clk_i(clk_i), .rst_n_i(rst_n), .start_i(start32), .ALU_Operation_i(op32),
    .A_i(a32), .B_i(b32), .ready_o(ready32), .valid_o(valid32),
    .ALU_Result_o(res32), .Zero_o(zero32)
  );

  multicycle_alu #(.WIDTH(8), .LUI_SHIFT(4)) u_dut8 (
    .clk_i(clk_i), .rst_n_i(rst_n), .start_i(start8), .ALU_Operation_i(op8),
    .A_i(a8), .B_i(b8), .ready_o(ready8), .valid_o(valid8),
    .ALU_Result_o(res8), .Zero_o(zero8)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: busy-cycle count and result straight from the opcode table
  function automatic int ref_n(input int w, input logic [3:0] op, input logic [31:0] b);
    int amt;
    amt = int'(b % 32'(w));
    if (op == 4'd6 || op == 4'd7) return (amt == 0) ? 1 : amt;
    if (op == 4'd10 && MUL_EN) return w;
    return 1;
  endfunction

  function automatic logic [31:0] ref_res(input int w, input int lui, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    logic [31:0] r;
    int amt;
    m   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    amt = int'(b % 32'(w));
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a | b;
      4'd3:    r = a & b;
      4'd4:    r = a ^ b;
      4'd5:    r = b << lui;
      4'd6:    r = a << amt;
      4'd7:    r = (a & m) >> amt;
      4'd8:    r = b - a;
      4'd9:    r = ((a & m) == (b & m)) ? 32'd1 : 32'd0;
      4'd10:   r = MUL_EN ? a * b : 32'd0;
      default: r = 32'd0;
    endcase
    return r & m;
  endfunction

  int          cyc[2]    = '{0, 0};
  bit          m_busy[2] = '{1'b0, 1'b0};
  int          m_done[2] = '{0, 0};
  logic [31:0] m_pend[2] = '{32'd0, 32'd0};
  logic [31:0] m_out[2]  = '{32'd0, 32'd0};
  bit          m_zero[2] = '{1'b1, 1'b1};

  task automatic m_reset(input int i);
    cyc[i] = 0; m_busy[i] = 1'b0; m_done[i] = 0; m_out[i] = '0; m_zero[i] = 1'b1;
  endtask

  task automatic m_step(input int i, input logic st, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int w;
    int lui;
    w   = (i == 0) ? 32 : 8;
    lui = (i == 0) ? 12 : 4;
    cyc[i]++;
    if (!m_busy[i]) begin
      if (st) begin
        m_pend[i] = ref_res(w, lui, op, a, b);
        m_busy[i] = 1'b1;
        m_done[i] = cyc[i] + ref_n(w, op, b);
      end
    end else if (cyc[i] == m_done[i]) begin
      m_out[i]  = m_pend[i];
      m_zero[i] = (m_pend[i] == 32'd0);
    end else if (cyc[i] == m_done[i] + 1) begin
      m_busy[i] = 1'b0;
    end
  endtask

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0, start32, op32, a32, b32);
      m_step(1, start8, op8, {24'h0, a8}, {24'h0, b8});
    end
  end

  always @(negedge clk_i) begin
    chk("dut32_ready",  32'(ready32), 32'(!m_busy[0]));
    chk("dut32_valid",  32'(valid32), 32'(m_busy[0] && cyc[0] == m_done[0]));
    chk("dut32_result", res32,        m_out[0]);
    chk("dut32_zero",   32'(zero32),  32'(m_zero[0]));
    chk("dut8_ready",   32'(ready8),  32'(!m_busy[1]));
    chk("dut8_valid",   32'(valid8),  32'(m_busy[1] && cyc[1] == m_done[1]));
    chk("dut8_result",  32'(res8),    m_out[1]);
    chk("dut8_zero",    32'(zero8),   32'(m_zero[1]));
  end

  task automatic drive(input int i, input logic s, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      start32 = s; op32 = op; a32 = a; b32 = b;
    end else begin
      start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic logic rdy(input int i);
    return (i == 0) ? ready32 : ready8;
  endfunction

  function automatic logic vld(input int i);
    return (i == 0) ? valid32 : valid8;
  endfunction

  // Issue one op from a negedge; k = busy cycles seen before valid_o
  task automatic run_op(input int i, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int k, output logic [31:0] r,
                        output logic z);
    int g;
    g = 0;
    while (!rdy(i) && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    if (g >= 100) chk("ready_timeout", 32'(g), 32'd0);
    drive(i, 1'b1, op, a, b);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(i, 1'b0, 4'($urandom), $urandom, $urandom);
    k = 0;
    while (!vld(i) && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 200) chk("valid_timeout", 32'(k), 32'd0);
    r = (i == 0) ? res32 : {24'h0, res8};
    z = (i == 0) ? zero32 : zero8;
  endtask

  initial begin
    int          k;
    int          nv;
    logic [31:0] r;
    logic        z;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk_i);
    chk("rst32_ready", 32'(ready32), 32'd1);
    chk("rst32_valid", 32'(valid32), 32'd0);
    chk("rst32_res",   res32,        32'd0);
    chk("rst32_zero",  32'(zero32),  32'd1);
    chk("rst8_ready",  32'(ready8),  32'd1);
    chk("rst8_zero",   32'(zero8),   32'd1);
    rst_n = 1'b1;
    @(negedge clk_i);

    run_op(0, 4'd0, 32'h7FFF_FFFF, 32'h1, k, r, z);
    chk("add_res", r, 32'h8000_0000); chk("add_zero", 32'(z), 32'd0); chk("add_lat", 32'(k), 32'd1);
    run_op(0, 4'd1, 32'd5, 32'd5, k, r, z);
    chk("sub_res", r, 32'd0); chk("sub_zero", 32'(z), 32'd1);
    run_op(0, 4'd6, 32'd1, 32'h0000_0105, k, r, z);
    chk("sll_res", r, 32'h20); chk("sll_lat", 32'(k), 32'd5);
    run_op(0, 4'd7, 32'h8000_0000, 32'd31, k, r, z);
    chk("srl_res", r, 32'd1); chk("srl_lat", 32'(k), 32'd31);
    run_op(0, 4'd6, 32'h0000_1234, 32'h20, k, r, z);
    chk("sll0_res", r, 32'h1234); chk("sll0_lat", 32'(k), 32'd1);
    run_op(0, 4'd5, 32'd0, 32'h000A_BCDE, k, r, z);
    chk("lui_res", r, 32'hABCD_E000);
    run_op(0, 4'd9, 32'd7, 32'd7, k, r, z);
    chk("bne_res", r, 32'd1);
    run_op(0, 4'd8, 32'd3, 32'd3, k, r, z);
    chk("beq_res", r, 32'd0); chk("beq_zero", 32'(z), 32'd1);
    run_op(0, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, k, r, z);
    chk("op15_res", r, 32'd0); chk("op15_lat", 32'(k), 32'd1);
    run_op(0, 4'd10, 32'hFFFF_FFFF, 32'd3, k, r, z);
    if (MUL_EN) begin
      chk("mul_res", r, 32'hFFFF_FFFD); chk("mul_lat", 32'(k), 32'd32);
    end else begin
      chk("mul_off_res", r, 32'd0); chk("mul_off_zero", 32'(z), 32'd1);
      chk("mul_off_lat", 32'(k), 32'd1);
    end
    run_op(1, 4'd7, 32'h80, 32'd7, k, r, z);
    chk("w8_srl_res", r, 32'd1); chk("w8_srl_lat", 32'(k), 32'd7);

    // start_i held high through a 20-cycle SLL, then kept high as ready returns
    drive(0, 1'b1, 4'd6, 32'd1, 32'd20);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(0, 1'b1, 4'd0, 32'd2, 32'd3);
    k = 0;
    while (!valid32 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk("hs_sll_lat", 32'(k), 32'd20);
    chk("hs_sll_res", res32, 32'h0010_0000);
    @(negedge clk_i);
    chk("hs_ready_back", 32'(ready32), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("hs_accepted", 32'(ready32), 32'd0);
    k = 0;
    while (!valid32 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk("hs_add_lat", 32'(k), 32'd1);
    chk("hs_add_res", res32, 32'd5);

    // Asynchronous reset in the middle of a long operation
    @(negedge clk_i);
    drive(0, 1'b1, MUL_EN ? 4'd10 : 4'd7, 32'hFFFF_FFFF, 32'd30);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (10) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready32), 32'd1);
    chk("midrst_valid", 32'(valid32), 32'd0);
    chk("midrst_res",   res32,        32'd0);
    chk("midrst_zero",  32'(zero32),  32'd1);
    @(negedge clk_i);
    rst_n = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid32) nv++;
    end
    chk("midrst_no_stale_valid", 32'(nv), 32'd0);

    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op(0, rop, ra, rb, k, r, z);
      chk("rnd32_lat", 32'(k), 32'(ref_n(32, rop, rb)));
      if ($urandom_range(0, 3) == 0) @(negedge clk_i);
    end
    for (int n = 0; n < 100; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 32'($urandom_range(0, 255));
      rb  = 32'($urandom_range(0, 255));
      run_op(1, rop, ra, rb, k, r, z);
      chk("rnd8_lat", 32'(k), 32'(ref_n(8, rop, rb)));
    end

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered successor to the datapath's combinational 32-bit ALU. It keeps the existing 4-bit operation encoding and adds a start/ready/valid handshake. Shifts run iteratively, one bit per cycle, and an optional iterative shift-add multiplier is included. It sits in the execute stage of the multi-cycle core; the control FSM issues an operation and waits for `valid_o` before writing back.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `LUI_SHIFT`, 12: left-shift applied to `B_i` for LUI; must be < `WIDTH`.
- Derived, not overridable: `SHAMT_W` = $clog2(`WIDTH`).

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_n_i` in 1: asynchronous reset, active-low.
- `start_i` in 1: request; accepted only on a rising edge where `ready_o`=1.
- `ALU_Operation_i` in 4: operation code, sampled at accept.
- `A_i` in `WIDTH`: operand A, sampled at accept.
- `B_i` in `WIDTH`: operand B, sampled at accept.
- `ready_o` out 1: high only in IDLE.
- `valid_o` out 1: one-cycle pulse; result and zero flag are valid.
- `ALU_Result_o` out `WIDTH`: registered result; holds until the next `valid_o`.
- `Zero_o` out 1: registered; 1 when the result equals 0; updates with `ALU_Result_o`.

## Operation
- FSM states: IDLE → BUSY → DONE → IDLE.
  - IDLE + `start_i`: latch the opcode and operands, enter BUSY.
  - BUSY lasts N cycles, as listed under Opcodes.
  - DONE lasts one cycle; `valid_o`=1 and `ready_o`=0.
- Opcodes and results. Arithmetic wraps modulo 2^`WIDTH`; no carry or overflow outputs.
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 OR, 3 AND, 4 XOR: bitwise.
  - 5 LUI: B<<`LUI_SHIFT`.
  - 8 BEQ: B−A.
  - 9 BNE: (A==B), zero-extended.
  - All of the above have N=1.
  - 6 SLL and 7 SRL (logical): shift amount = B[`SHAMT_W`-1:0]; upper bits of B are ignored. One bit is shifted per BUSY cycle, so N = max(1, amount). Amount 0 returns A unchanged.
  - 10 MUL: see Configuration.
  - 11–15: result 0, N=1.
- `start_i` while `ready_o`=0 is ignored; there is no queueing.
- Inputs may change freely after the accept edge; the internal copies are used.
- `ALU_Result_o` and `Zero_o` are written only on the BUSY→DONE edge and otherwise hold.

## Timing
- Reset values (async assert, immediate): state IDLE, `ready_o`=1, `valid_o`=0, `ALU_Result_o`=0, `Zero_o`=1, internal counters 0.
- Reset deassertion is synchronised externally; the block is usable on the first rising edge after deassertion.
- Accept edge e0 → BUSY for N cycles → `valid_o` is high in cycle N+1 after e0. Single-cycle ops: `valid_o` is high in the 2nd cycle after accept.
- `ready_o` falls the cycle after accept and returns the cycle after `valid_o`.
- Issue interval for back-to-back operations: N+2 cycles.
- Reset asserted mid-BUSY or mid-DONE: the operation is discarded, no `valid_o` is issued, and outputs return to reset values.
- The shift counter and the multiply counter are `SHAMT_W`+1 bits. SLL/SRL by `WIDTH`−1 takes exactly `WIDTH`−1 BUSY cycles.

## Configuration
- Macro: `MULTICYCLE_ALU_MUL_EN`.
- Defined: opcode 10 MUL returns the low `WIDTH` bits of A×B.
  - Radix-2 shift-add, one multiplier bit per cycle; N=`WIDTH`.
  - Sign-agnostic, since only the low half is returned.
- Undefined: no multiplier hardware is present; opcode 10 behaves as 11–15 (result 0, `Zero_o`=1, N=1).

## Test plan
- Reset then ADD A=0x7FFF_FFFF, B=1 → `ALU_Result_o`=0x8000_0000, `Zero_o`=0, `valid_o` in the 2nd cycle after accept. SUB A=5, B=5 → 0, `Zero_o`=1.
- SLL A=1, B=0x0000_0105 (amount 5) → 0x20 after 5 BUSY cycles. SRL A=0x8000_0000, B=31 → 1 after 31 BUSY cycles. SLL with amount 0 → A, N=1.
- LUI B=0xABCDE → 0xABCD_E000. BNE A=B=7 → 1. BEQ A=3, B=3 → 0, `Zero_o`=1. Opcode 15 → 0.
- With `MULTICYCLE_ALU_MUL_EN`: MUL A=0xFFFF_FFFF, B=3 → 0xFFFF_FFFD with `valid_o` 33 cycles after accept. Without the macro: opcode 10 → 0, `Zero_o`=1.
- Handshake: pulse `start_i` every cycle during a 20-cycle SLL → only the first request is executed. Then drive `start_i` in the cycle `ready_o` returns → accepted.
- Assert `rst_n_i` low mid-MUL → immediately `ready_o`=1, `valid_o`=0, result 0, `Zero_o`=1; no stale `valid_o` after release. Repeat with `WIDTH`=8: SRL A=0x80, B=7 → 1.
